// File: rtl/cornet_bus_pkg.sv
// Shared types for the Cornet/CLC88 bus master: FSM state encoding and bus direction values.
package cornet_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } bus_state_t;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    // Index width that never collapses to zero for a single-entry range.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cornet_bus_arbiter.sv
// Combinational channel arbiter: search starts just above the last-winner pointer.
// A pointer fixed at NUM_CH-1 gives plain lowest-index-wins priority.
module cornet_bus_arbiter
    import cornet_bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos = IDX_W'((int'(ptr) + 1 + i) % NUM_CH);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/cornet_bus_master.sv
// Multi-channel byte-beat bus master for the Cornet/CLC88 memory bus.
// Define CORNET_BUS_RR_EN for round-robin arbitration; default is fixed priority.
//
// state | meaning
// IDLE  | waiting for a request; grant latches the winner's request fields
// BEAT  | strobe high for byte[counter] until bus_ack
// GAP   | one strobes-low cycle so every beat starts with a fresh strobe edge
// DONE  | one-cycle req_done pulse to the winner
module cornet_bus_master
    import cornet_bus_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 16,
    parameter int MAX_BYTES = 2,
    parameter int LEN_W     = clog2_min1(MAX_BYTES)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH-1:0]             req_write,
    input  logic [NUM_CH*LEN_W-1:0]       req_len,
    input  logic [NUM_CH*ADDR_W-1:0]      req_addr,
    input  logic [NUM_CH*MAX_BYTES*8-1:0] req_wdata,
    output logic [NUM_CH-1:0]             req_done,
    output logic [MAX_BYTES*8-1:0]        rsp_data,
    output logic                          busy,
    output logic [ADDR_W-1:0]             bus_addr,
    output logic [7:0]                    bus_wr_data,
    output logic                          bus_rd_req,
    output logic                          bus_wr_req,
    input  logic                          bus_ack,
    input  logic [7:0]                    bus_rd_data
);

    localparam int IDX_W = clog2_min1(NUM_CH);
    localparam int DW    = MAX_BYTES * 8;

    bus_state_t        state_q, state_d;
    logic [NUM_CH-1:0] win_q;
    logic              write_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     rsp_q;

    logic [NUM_CH-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;
    logic [IDX_W-1:0]  arb_ptr;
    logic              take;

    logic              sel_write;
    logic [LEN_W-1:0]  sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [7:0]        wr_byte;
    logic              strobe;
    logic              last_beat;

    assign take = (state_q == IDLE) && arb_any;

    // Lengths that do not fit MAX_BYTES are limited to a full-width transfer.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (int'(l) > MAX_BYTES - 1)
            return LEN_W'(MAX_BYTES - 1);
        return l;
    endfunction

`ifdef CORNET_BUS_RR_EN
    logic [IDX_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            last_q <= IDX_W'(NUM_CH - 1);
        else if (take)
            last_q <= arb_idx;
    end

    assign arb_ptr = last_q;
`else
    assign arb_ptr = IDX_W'(NUM_CH - 1);
`endif

    cornet_bus_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arbiter (
        .req   (req_valid),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_len   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (arb_idx == IDX_W'(c)) begin
                sel_write = req_write[c];
                sel_len   = clamp_len(req_len[c*LEN_W +: LEN_W]);
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*DW +: DW];
            end
        end
    end

    always_comb begin
        wr_byte = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (cnt_q == LEN_W'(k))
                wr_byte = wdata_q[8*k +: 8];
        end
    end

    assign last_beat = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = BEAT;
            BEAT:    if (bus_ack) state_d = last_beat ? DONE : GAP;
            GAP:     state_d = BEAT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            write_q <= RD;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        win_q   <= arb_grant;
                        write_q <= sel_write;
                        len_q   <= sel_len;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        cnt_q   <= '0;
                        rsp_q   <= '0;
                    end
                end
                BEAT: begin
                    if (bus_ack) begin
                        if (write_q == RD) begin
                            for (int k = 0; k < MAX_BYTES; k++) begin
                                if (cnt_q == LEN_W'(k))
                                    rsp_q[8*k +: 8] <= bus_rd_data;
                            end
                        end
                        if (!last_beat)
                            cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // All bus outputs are decoded from registered state, so they are clean after reset.
    assign strobe      = (state_q == BEAT);
    assign bus_rd_req  = strobe && (write_q == RD);
    assign bus_wr_req  = strobe && (write_q == WR);
    assign bus_addr    = strobe ? (addr_q + ADDR_W'(cnt_q)) : '0;
    assign bus_wr_data = (strobe && (write_q == WR)) ? wr_byte : 8'h00;
    assign busy        = (state_q == BEAT) || (state_q == GAP);
    assign req_done    = (state_q == DONE) ? win_q : '0;
    assign rsp_data    = rsp_q;

endmodule
